// File: rtl/serial_byte_subtractor.sv
// serial_byte_subtractor
// Bit-serial subtractor that computes diff = minuend - subtrahend - bin.
// It handles one bit per clock, starting with the LSB. The unit uses a
// start/busy/done handshake. It is built as the companion of the bit-serial
// byte adder: fewer gates, at the cost of WIDTH+1 cycles of latency.
module serial_byte_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // The counter must be able to reach WIDTH so that it never wraps
  // within one operation.
  localparam int COUNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   aSh_q,    aSh_d;
  logic [WIDTH-1:0]   bSh_q,    bSh_d;
  logic [WIDTH-1:0]   rSh_q,    rSh_d;
  logic [WIDTH-1:0]   diff_q,   diff_d;
  logic               borrow_q, borrow_d;
  logic               bout_q,   bout_d;
  logic [COUNT_W-1:0] count_q,  count_d;

  logic bitA;
  logic bitB;
  logic bitD;
  logic borrowNext;
  logic lastBit;

  // One-bit full subtractor over the current LSBs and the running borrow.
  always_comb begin
    bitA       = aSh_q[0];
    bitB       = bSh_q[0];
    bitD       = bitA ^ bitB ^ borrow_q;
    borrowNext = (~bitA & bitB) | (~bitA & borrow_q) | (bitB & borrow_q);
    lastBit    = (count_q == COUNT_W'(WIDTH - 1));
  end

  // Next-state logic. Every register holds its value unless the current
  // state updates it. diff and bout load only on the final bit, so outside
  // of reset they never show a partial result.
  always_comb begin
    state_d  = state_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    rSh_d    = rSh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          aSh_d    = minuend;
          bSh_d    = subtrahend;
          borrow_d = bin;
          rSh_d    = '0;
          count_d  = '0;
        end
      end
      SHIFT: begin
        aSh_d    = aSh_q >> 1;
        bSh_d    = bSh_q >> 1;
        rSh_d    = {bitD, rSh_q[WIDTH-1:1]};
        borrow_d = borrowNext;
        count_d  = count_q + COUNT_W'(1);
        if (lastBit) begin
          diff_d  = {bitD, rSh_q[WIDTH-1:1]};
          bout_d  = borrowNext;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is synchronous, and asserting it
  // mid-operation aborts the operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aSh_q    <= '0;
      bSh_q    <= '0;
      rSh_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      rSh_q    <= rSh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      count_q  <= count_d;
    end
  end

  // Handshake outputs come straight from the state register. DONE lasts
  // exactly one cycle, so done is a one-cycle pulse.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_byte_subtractor.sv
// tb_serial_byte_subtractor
// Scoreboard bench for the bit-serial subtractor. Each accepted start
// pushes the expected result and completion cycle. Each done pulse pops
// one entry and compares against it.
module tb_serial_byte_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  typedef struct {
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] s;
    logic             b;
    logic [WIDTH-1:0] expDiff;
    logic             expBout;
    int               acceptEdge;
  } expect_t;

  expect_t scoreQ[$];
  int      checkCount = 0;
  int      errorCount = 0;
  int      cycleCount = 0;
  logic    prevDone   = 1'b0;

  serial_byte_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .bout       (bout)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges so that completion latency can be checked.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Compares one observed value with its expected value and logs a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d",
               tag, observed, expected, cycleCount);
    end
  endtask

  // Waits, at falling edges, until the unit is idle. The wait is bounded.
  task automatic waitIdle();
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("idleTimeout", 32'd1, 32'd0);
  endtask

  // Issues one operation and records its expected result. When useKnown is
  // set, the caller supplies the answer. Otherwise the reference model
  // computes it.
  task automatic applyStimulus(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s,
                               input logic b, input logic useKnown,
                               input logic [WIDTH-1:0] knownDiff, input logic knownBout);
    expect_t  e;
    logic [WIDTH:0] wide;
    waitIdle();
    wide = {1'b0, m} - {1'b0, s} - {{WIDTH{1'b0}}, b};
    e.m          = m;
    e.s          = s;
    e.b          = b;
    e.expDiff    = useKnown ? knownDiff : wide[WIDTH-1:0];
    e.expBout    = useKnown ? knownBout : wide[WIDTH];
    e.acceptEdge = cycleCount + 1;
    scoreQ.push_back(e);
    minuend    = m;
    subtrahend = s;
    bin        = b;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    minuend    = WIDTH'($urandom);
    subtrahend = WIDTH'($urandom);
    bin        = 1'($urandom);
    checkOutput("accepted", {31'd0, busy}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on each done pulse and checks the result,
  // the latency, the adder identity and the pulse width.
  always @(negedge clk) begin
    expect_t e;
    logic [WIDTH-1:0] back;
    if (prevDone) checkOutput("donePulseWidth", {31'd0, done}, 32'd0);
    if (done === 1'b1 && !prevDone) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = scoreQ.pop_front();
        checkOutput("diff", {24'd0, diff}, {24'd0, e.expDiff});
        checkOutput("bout", {31'd0, bout}, {31'd0, e.expBout});
        checkOutput("latency", cycleCount, e.acceptEdge + WIDTH);
        if (bout === 1'b0) begin
          back = diff + e.s + {{(WIDTH-1){1'b0}}, e.b};
          checkOutput("adderIdentity", {24'd0, back}, {24'd0, e.m});
        end
      end
    end
    prevDone <= done;
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    bin        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetDiff", {24'd0, diff}, 32'd0);
    checkOutput("resetBout", {31'd0, bout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer cases.
    applyStimulus(8'h81, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1);
    applyStimulus(8'h81, 8'h2C, 1'b1, 1'b1, 8'h54, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1);
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);

    // Back-to-back sweep at minimum start spacing.
    for (int s = 0; s <= 8'h58; s += 2) begin
      for (int b = 0; b < 2; b++) begin
        applyStimulus(8'h81, WIDTH'(s), 1'(b), 1'b0, '0, 1'b0);
      end
    end

    // Random operands.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
    end

    // Hold start high during SHIFT with new operands. Only the first
    // operands may complete.
    waitIdle();
    scoreQ.push_back('{m: 8'h90, s: 8'h10, b: 1'b0, expDiff: 8'h80, expBout: 1'b0,
                       acceptEdge: cycleCount + 1});
    minuend    = 8'h90;
    subtrahend = 8'h10;
    bin        = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      minuend    = WIDTH'($urandom);
      subtrahend = WIDTH'($urandom);
      bin        = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;

    // Abort with a one-cycle reset on the edge that would process bit 4.
    waitIdle();
    minuend    = 8'h33;
    subtrahend = 8'h77;
    bin        = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    checkOutput("abortDiff", {24'd0, diff}, 32'd0);
    checkOutput("abortBout", {31'd0, bout}, 32'd0);
    repeat (WIDTH + 2) @(negedge clk);
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1);

    // Drain the scoreboard.
    for (int i = 0; i < 50 && scoreQ.size() != 0; i++) @(negedge clk);
    checkOutput("queueDrained", scoreQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
